// File: rtl/spi_master_param_pkg.sv
// Shared types and helpers for the parametrised SPI master.
//   spi_state_t : transfer FSM states (IDLE, SETUP, SHIFT, HOLD)
//   MODE0..3    : {CPOL,CPHA} encodings
//   cs_w()      : width of the slave-select index, at least 1 bit
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int cs_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_param_clk_div.sv
// SCLK generator for the SPI master.
// While run=1 a half-period counter counts CLK_DIV-1..0; each expiry is one
// SCLK edge. Edges are numbered 0..2*WORD_W-1; even indices are leading
// edges, odd indices trailing edges. Once all edges have been produced the
// block parks with sclk back at CPOL and raises last.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   run          high while the master is in its shift phase
//   cpol         clock idle level
//   sclk         SPI clock
//   lead, trail  one-cycle strobes, high in the cycle whose edge toggles sclk
//   final_edge   strobe qualifying the last trailing edge of the word
//   last         all edges produced; master may leave the shift phase
module spi_clk_div #(
  parameter int WORD_W  = 32,
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic cpol,
  output logic sclk,
  output logic lead,
  output logic trail,
  output logic final_edge,
  output logic last
);

  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EC_W = $clog2(2 * WORD_W + 1);
  localparam logic [HC_W-1:0] HC_LOAD  = HC_W'(CLK_DIV - 1);
  localparam logic [EC_W-1:0] EC_END   = EC_W'(2 * WORD_W);
  localparam logic [EC_W-1:0] EC_FINAL = EC_W'(2 * WORD_W - 1);

  logic [HC_W-1:0] half_cnt;
  logic [EC_W-1:0] edge_cnt;
  logic            phase;
  logic            tick;

  assign last       = run && (edge_cnt == EC_END);
  assign tick       = run && (edge_cnt != EC_END) && (half_cnt == '0);
  assign lead       = tick && !edge_cnt[0];
  assign trail      = tick &&  edge_cnt[0];
  assign final_edge = tick && (edge_cnt == EC_FINAL);

  // sclk is CPOL xor an edge-parity bit, so it follows a newly latched CPOL
  // immediately and is back at CPOL after an even number of edges.
  assign sclk = cpol ^ phase;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      half_cnt <= HC_LOAD;
      edge_cnt <= '0;
      phase    <= 1'b0;
    end else if (tick) begin
      half_cnt <= HC_LOAD;
      edge_cnt <= edge_cnt + EC_W'(1);
      phase    <= ~phase;
    end else if (edge_cnt != EC_END) begin
      half_cnt <= half_cnt - HC_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: one WORD_W-bit word per transfer, SPI modes 0-3,
// MSB- or LSB-first, one of N_CS slave selects.
// Optional feature macro: SPI_LOOPBACK_EN adds input 'loopback'; when set at
// accept, received bits are taken from mosi and no ss_n line is asserted.
// Handshake: start is accepted on a clock edge where the FSM is IDLE
// (busy=0, which includes the done cycle); wr_data/mode/lsb_first/cs_sel are
// latched on that edge. busy is high from the next cycle until the cycle
// before done. done is a one-cycle pulse; rd_data is valid from that cycle
// and held until the next done. start while busy is dropped, not queued.
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   start, wr_data, mode,
//   lsb_first, cs_sel           transfer request and its settings
//   busy, done, rd_data         transfer status and received word
//   sclk, ss_n, mosi, miso      SPI pins
//   state_dbg                   current FSM state (spi_state_t encoding)
module spi_master_param
  import spi_pkg::*;
#(
  parameter int  WORD_W  = 32,
  parameter int  CLK_DIV = 2,
  parameter int  N_CS    = 1,
  localparam int CS_W    = cs_w(N_CS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rd_data,
  output logic              sclk,
  output logic [N_CS-1:0]   ss_n,
  output logic              mosi,
  input  logic              miso,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

  spi_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        mode_q;
  logic              lsb_q;
  logic [CS_W-1:0]   cs_q;
  logic [WORD_W-1:0] tx_sr;
  logic [WORD_W-1:0] rx_sr;
  logic [WORD_W-1:0] rd_q;
  logic              mosi_q;
  logic              done_q;
  logic              accept;
  logic              hold_exit;
  logic              lead, trail, final_edge, shift_last;
  logic              sample_stb, drive_stb;
  logic              rx_bit, tx_bit, ss_block;

  spi_clk_div #(
    .WORD_W  (WORD_W),
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk        (clk),
    .reset      (reset),
    .run        (state_q == SHIFT),
    .cpol       (mode_q[1]),
    .sclk       (sclk),
    .lead       (lead),
    .trail      (trail),
    .final_edge (final_edge),
    .last       (shift_last)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    hold_exit = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) state_d = SHIFT;
      end
      SHIFT: begin
        if (shift_last) state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          hold_exit = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SETUP/HOLD dwell counter, reloaded on every state change.
  always_ff @(posedge clk) begin
    if (reset)                   cnt_q <= CNT_LOAD;
    else if (state_d != state_q) cnt_q <= CNT_LOAD;
    else if (cnt_q != '0)        cnt_q <= cnt_q - CNT_W'(1);
  end

  // ---------------- transfer settings ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE0;
      lsb_q  <= 1'b0;
      cs_q   <= '0;
    end else if (accept) begin
      mode_q <= mode;
      lsb_q  <= lsb_first;
      cs_q   <= cs_sel;
    end
  end

`ifdef SPI_LOOPBACK_EN
  logic lb_q;
  always_ff @(posedge clk) begin
    if (reset)       lb_q <= 1'b0;
    else if (accept) lb_q <= loopback;
  end
  assign rx_bit   = lb_q ? mosi_q : miso;
  assign ss_block = lb_q;
`else
  assign rx_bit   = miso;
  assign ss_block = 1'b0;
`endif

  // ---------------- shift datapath ----------------
  // CPHA=0: first bit goes out at accept, so tx_sr is preloaded already
  // shifted and the remaining bits go out on trailing edges except the last.
  // CPHA=1: tx_sr is preloaded unshifted; every leading edge drives the next
  // bit, the first one re-driving the bit already on mosi.
  assign sample_stb = mode_q[0] ? trail : lead;
  assign drive_stb  = mode_q[0] ? lead  : (trail && !final_edge);
  assign tx_bit     = lsb_q ? tx_sr[0] : tx_sr[WORD_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sr  <= '0;
      rx_sr  <= '0;
      mosi_q <= 1'b0;
      rd_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= hold_exit;
      if (accept) begin
        mosi_q <= lsb_first ? wr_data[0] : wr_data[WORD_W-1];
        rx_sr  <= '0;
        if (mode[0])        tx_sr <= wr_data;
        else if (lsb_first) tx_sr <= wr_data >> 1;
        else                tx_sr <= wr_data << 1;
      end else begin
        if (drive_stb) begin
          mosi_q <= tx_bit;
          tx_sr  <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
        end
        if (sample_stb) begin
          rx_sr <= lsb_q ? {rx_bit, rx_sr[WORD_W-1:1]}
                         : {rx_sr[WORD_W-2:0], rx_bit};
        end
      end
      if (hold_exit) rd_q <= rx_sr;
    end
  end

  // ---------------- slave select decode ----------------
  // An out-of-range index matches no line, so all selects stay high.
  always_comb begin
    ss_n = '1;
    for (int i = 0; i < N_CS; i++) begin
      if (state_q != IDLE && !ss_block && cs_q == CS_W'(i)) ss_n[i] = 1'b0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rd_data   = rd_q;
  assign mosi      = mosi_q;
  assign state_dbg = state_q;

endmodule
